// File: rtl/i2s_sync.sv
// i2s_sync: two-flop synchronizer plus one delay stage for a single
// asynchronous I2S input, with a rising-edge strobe derived from the pair.
module i2s_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise_c
);

    logic r_meta;
    logic r_sync;
    logic r_dly;

    // Synchronizer chain followed by the edge-detect delay stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_dly  <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_dly  <= r_sync;
        end
    end

    assign o_sync   = r_sync;
    assign o_rise_c = r_sync & ~r_dly;

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S receiver. Recovers SCK edges in the clk domain, frames words on
// word-select transitions, assembles left/right pairs and presents them
// through a valid/ready holding register with sticky overrun/sync flags.
module i2s_rx #(
    parameter int unsigned BITS_PER_CHANNEL = 32,
    parameter int unsigned SAMPLE_WIDTH     = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sck,
    input  logic                    lrclk,
    input  logic                    dat,
    input  logic                    frame_ready,
    input  logic                    err_clr,
    output logic [SAMPLE_WIDTH-1:0] left_data,
    output logic [SAMPLE_WIDTH-1:0] right_data,
    output logic                    frame_valid,
    output logic                    overrun,
    output logic                    sync_err
);

    localparam int unsigned CNT_W = $clog2(BITS_PER_CHANNEL + 2);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(BITS_PER_CHANNEL + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BITS_PER_CHANNEL);
    localparam logic [CNT_W-1:0] CNT_SAMP = CNT_W'(SAMPLE_WIDTH);

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_LEFT    = 2'd1,
        ST_RIGHT   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic w_sck_sync;
    logic w_sck_rise;
    logic w_lr;
    logic w_lr_rise;
    logic w_dat;
    logic w_dat_rise;
    logic w_unused_sync;

    logic                    r_lr_prev;
    logic [CNT_W-1:0]        r_cnt;
    logic [SAMPLE_WIDTH-1:0] r_shift;
    logic [SAMPLE_WIDTH-1:0] r_pend_left;

    logic                    w_strobe;
    logic                    w_word_end;
    logic [CNT_W-1:0]        w_cnt_inc;
    logic                    w_len_ok;
    logic [SAMPLE_WIDTH-1:0] w_shift_nxt;
    logic                    w_latch_left;
    logic                    w_frame_done;
    logic                    w_sync_evt;
    logic                    w_hs;
    logic                    w_load;
    logic                    w_drop;

    i2s_sync u_sync_sck (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_async  (sck),
        .o_sync   (w_sck_sync),
        .o_rise_c (w_sck_rise)
    );

    i2s_sync u_sync_lr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_async  (lrclk),
        .o_sync   (w_lr),
        .o_rise_c (w_lr_rise)
    );

    i2s_sync u_sync_dat (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_async  (dat),
        .o_sync   (w_dat),
        .o_rise_c (w_dat_rise)
    );

    // Only the SCK edge and the level of word-select/data are consumed
    assign w_unused_sync = w_sck_sync ^ w_lr_rise ^ w_dat_rise;

    assign w_strobe    = w_sck_rise;
    assign w_word_end  = w_strobe & (w_lr != r_lr_prev);
    assign w_cnt_inc   = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_len_ok    = (w_cnt_inc == CNT_FULL);
    assign w_shift_nxt = (r_cnt < CNT_SAMP) ? {r_shift[SAMPLE_WIDTH-2:0], w_dat} : r_shift;

    // Bit sampling, word-length counting and sample shifting per SCK strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lr_prev   <= 1'b0;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_pend_left <= '0;
        end else if (w_strobe) begin
            r_lr_prev <= w_lr;
            r_shift   <= w_shift_nxt;
            r_cnt     <= w_word_end ? '0 : w_cnt_inc;
            if (w_latch_left) begin
                r_pend_left <= w_shift_nxt;
            end
        end
    end

    // Framing state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACQUIRE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Framing next-state and word-end decisions
    always_comb begin
        w_state_nxt  = r_state;
        w_latch_left = 1'b0;
        w_frame_done = 1'b0;
        w_sync_evt   = 1'b0;
        if (w_word_end) begin
            case (r_state)
                ST_ACQUIRE: begin
                    // Right-to-left transition: next bit is a left MSB
                    if (r_lr_prev && !w_lr) begin
                        w_state_nxt = ST_LEFT;
                    end
                end
                ST_LEFT: begin
                    if (!w_len_ok) begin
                        w_sync_evt  = 1'b1;
                        w_state_nxt = ST_ACQUIRE;
                    end else begin
                        w_latch_left = 1'b1;
                        w_state_nxt  = ST_RIGHT;
                    end
                end
                ST_RIGHT: begin
                    if (!w_len_ok) begin
                        w_sync_evt  = 1'b1;
                        w_state_nxt = ST_ACQUIRE;
                    end else begin
                        w_frame_done = 1'b1;
                        w_state_nxt  = ST_LEFT;
                    end
                end
                default: begin
                    w_state_nxt = ST_ACQUIRE;
                end
            endcase
        end
    end

    assign w_hs   = frame_valid & frame_ready;
    assign w_load = w_frame_done & (~frame_valid | frame_ready);
    assign w_drop = w_frame_done & frame_valid & ~frame_ready;

    // Output holding register with valid/ready handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_data   <= '0;
            right_data  <= '0;
            frame_valid <= 1'b0;
        end else if (w_load) begin
            left_data   <= r_pend_left;
            right_data  <= w_shift_nxt;
            frame_valid <= 1'b1;
        end else if (w_hs) begin
            frame_valid <= 1'b0;
        end
    end

    // Sticky error flags; a new event outranks a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun  <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            if (w_drop) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
            if (w_sync_evt) begin
                sync_err <= 1'b1;
            end else if (err_clr) begin
                sync_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: drives word-level I2S streams with SCK = clk/16 and checks
// frames and flags against a word-level reference of the framing rules.
module tb_i2s_rx;

    localparam int unsigned BPC = 32;
    localparam int unsigned SW  = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sck;
    logic          lrclk;
    logic          dat;
    logic          frame_ready;
    logic          err_clr;
    logic [SW-1:0] left_data;
    logic [SW-1:0] right_data;
    logic          frame_valid;
    logic          overrun;
    logic          sync_err;

    int n_cmp = 0;
    int n_bad = 0;

    bit            mon_en = 1'b0;
    bit            q_ch[$];
    int            q_n[$];
    logic [SW-1:0] q_val[$];
    logic [SW-1:0] e_l[$];
    logic [SW-1:0] e_r[$];
    bit            e_err;
    logic [SW-1:0] pulse_l;
    logic [SW-1:0] pulse_r;

    always #5 clk = ~clk;

    i2s_rx #(.BITS_PER_CHANNEL(BPC), .SAMPLE_WIDTH(SW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sck         (sck),
        .lrclk       (lrclk),
        .dat         (dat),
        .frame_ready (frame_ready),
        .err_clr     (err_clr),
        .left_data   (left_data),
        .right_data  (right_data),
        .frame_valid (frame_valid),
        .overrun     (overrun),
        .sync_err    (sync_err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic add_word(input bit ch, input int n, input logic [SW-1:0] val);
        q_ch.push_back(ch);
        q_n.push_back(n);
        q_val.push_back(val);
    endtask

    task automatic add_frame(input logic [SW-1:0] l, input logic [SW-1:0] r);
        add_word(1'b0, BPC, l);
        add_word(1'b1, BPC, r);
    endtask

    // Word-level reference: acquire on a completed right word, then pair
    // full-length left/right words; any wrong-length word drops back to acquire.
    function automatic void model();
        int            st = 0;
        logic [SW-1:0] pl = '0;
        e_err = 1'b0;
        for (int k = 0; k < q_ch.size(); k++) begin
            if (st == 0) begin
                if (q_ch[k]) st = 1;
            end else if (q_n[k] != BPC) begin
                e_err = 1'b1;
                st    = 0;
            end else if (st == 1) begin
                pl = q_val[k];
                st = 2;
            end else begin
                e_l.push_back(pl);
                e_r.push_back(q_val[k]);
                st = 1;
            end
        end
    endfunction

    // One SCK period: data/word-select change with SCK low, sampled on the rise
    task automatic send_bit(input logic b, input logic lr, input bit pulse);
        sck   = 1'b0;
        dat   = b;
        lrclk = lr;
        repeat (8) @(negedge clk);
        sck = 1'b1;
        if (pulse) begin
            repeat (2) @(negedge clk);
            frame_ready = 1'b1;
            @(negedge clk);
            frame_ready = 1'b0;
            chk("race_valid", 32'(frame_valid), 32'd1);
            chk("race_left", 32'(left_data), 32'(pulse_l));
            chk("race_right", 32'(right_data), 32'(pulse_r));
            chk("race_overrun", 32'(overrun), 32'd0);
            repeat (5) @(negedge clk);
        end else begin
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic play(input int pulse_k);
        for (int k = 0; k < q_ch.size(); k++) begin
            logic        nxt;
            logic [31:0] slot;
            nxt  = (k + 1 < q_ch.size()) ? q_ch[k+1] : ~q_ch[k];
            slot = 32'(q_val[k]) << (32 - SW);
            for (int i = 0; i < q_n[k]; i++) begin
                logic b;
                b = (i < 32) ? slot[31-i] : 1'b0;
                send_bit(b, (i == q_n[k] - 1) ? nxt : q_ch[k], (k == pulse_k) && (i == q_n[k] - 1));
            end
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic clear_q();
        q_ch.delete();
        q_n.delete();
        q_val.delete();
        e_l.delete();
        e_r.delete();
        e_err = 1'b0;
    endtask

    task automatic do_reset();
        mon_en      = 1'b0;
        rst_n       = 1'b0;
        frame_ready = 1'b0;
        err_clr     = 1'b0;
        sck         = 1'b0;
        lrclk       = 1'b0;
        dat         = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_q();
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_stream_end(input string tag);
        chk({tag, "_frames_left"}, 32'(e_l.size()), 32'd0);
        chk({tag, "_sync_err"}, 32'(sync_err), 32'(e_err));
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    // Scoreboard: every accepted frame is compared against the reference queue
    always @(posedge clk) begin
        #1;
        if (mon_en && frame_valid && frame_ready) begin
            if (e_l.size() == 0) begin
                chk("extra_frame", 32'd1, 32'd0);
            end else begin
                chk("frame_left", 32'(left_data), 32'(e_l.pop_front()));
                chk("frame_right", 32'(right_data), 32'(e_r.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SW-1:0] l1, r1, l2, r2;

        // Reset values
        rst_n = 1'b0; frame_ready = 1'b0; err_clr = 1'b0;
        sck = 1'b0; lrclk = 1'b0; dat = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(frame_valid), 32'd0);
        chk("rst_left", 32'(left_data), 32'd0);
        chk("rst_right", 32'(right_data), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_sync_err", 32'(sync_err), 32'd0);

        // Fixed pattern stream
        do_reset();
        frame_ready = 1'b1;
        mon_en      = 1'b1;
        add_word(1'b1, BPC, 24'h5A5A5A);
        for (int f = 0; f < 3; f++) add_frame(24'hA5A5A5, 24'h5A5A5A);
        model();
        play(-1);
        check_stream_end("fixed");

        // Random samples, stream starting mid-right-word
        for (int it = 0; it < 2; it++) begin
            do_reset();
            frame_ready = 1'b1;
            mon_en      = 1'b1;
            add_word(1'b1, int'($urandom_range(20, 4)), SW'($urandom()));
            for (int f = 0; f < 4; f++) add_frame(SW'($urandom()), SW'($urandom()));
            model();
            play(-1);
            check_stream_end("rand");
        end

        // Short left word: error, frame lost, re-acquire
        do_reset();
        frame_ready = 1'b1;
        mon_en      = 1'b1;
        add_word(1'b1, BPC, SW'($urandom()));
        add_frame(SW'($urandom()), SW'($urandom()));
        add_word(1'b0, BPC - 1, SW'($urandom()));
        add_word(1'b1, BPC, SW'($urandom()));
        add_frame(SW'($urandom()), SW'($urandom()));
        add_frame(SW'($urandom()), SW'($urandom()));
        model();
        play(-1);
        chk("short_exp_err", 32'(e_err), 32'd1);
        chk("short_frames_left", 32'(e_l.size()), 32'd0);
        chk("short_sync_err", 32'(sync_err), 32'd1);
        pulse_err_clr();
        chk("short_sync_clr", 32'(sync_err), 32'd0);

        // Consumer stalled across two frames: hold first, drop second
        do_reset();
        l1 = SW'($urandom()); r1 = SW'($urandom());
        l2 = SW'($urandom()); r2 = SW'($urandom());
        add_word(1'b1, BPC, SW'($urandom()));
        add_frame(l1, r1);
        add_frame(l2, r2);
        model();
        play(-1);
        chk("stall_valid", 32'(frame_valid), 32'd1);
        chk("stall_left", 32'(left_data), 32'(e_l[0]));
        chk("stall_right", 32'(right_data), 32'(e_r[0]));
        chk("stall_overrun", 32'(overrun), 32'd1);
        pulse_err_clr();
        chk("stall_ovr_clr", 32'(overrun), 32'd0);
        chk("stall_still_valid", 32'(frame_valid), 32'd1);
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        chk("stall_released", 32'(frame_valid), 32'd0);

        // Handshake in the very cycle a new frame completes
        do_reset();
        l1 = SW'($urandom()); r1 = SW'($urandom());
        pulse_l = SW'($urandom()); pulse_r = SW'($urandom());
        add_word(1'b1, BPC, SW'($urandom()));
        add_frame(l1, r1);
        add_frame(pulse_l, pulse_r);
        play(4);
        chk("race_hold_left", 32'(left_data), 32'(pulse_l));
        chk("race_hold_ovr", 32'(overrun), 32'd0);
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        chk("race_released", 32'(frame_valid), 32'd0);

        // Reset pulse mid-word, then re-acquire from mid-right-word
        do_reset();
        add_word(1'b1, BPC, SW'($urandom()));
        add_frame(SW'($urandom()), SW'($urandom()));
        play(-1);
        chk("midrst_pre_valid", 32'(frame_valid), 32'd1);
        for (int i = 0; i < 10; i++) send_bit(1'($urandom()), 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(frame_valid), 32'd0);
        chk("midrst_left", 32'(left_data), 32'd0);
        chk("midrst_right", 32'(right_data), 32'd0);
        chk("midrst_overrun", 32'(overrun), 32'd0);
        chk("midrst_sync_err", 32'(sync_err), 32'd0);
        sck = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_q();
        frame_ready = 1'b1;
        mon_en      = 1'b1;
        add_word(1'b1, 13, SW'($urandom()));
        add_frame(SW'($urandom()), SW'($urandom()));
        add_frame(SW'($urandom()), SW'($urandom()));
        model();
        play(-1);
        check_stream_end("reacq");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter BITS_PER_CHANNEL, default 32, SCK periods per channel slot.
REQ-002 Parameter SAMPLE_WIDTH, default 24, captured MSB-first bits per channel (SAMPLE_WIDTH <= BITS_PER_CHANNEL).
REQ-003 clk  input  1  system clock, at least 4x SCK frequency.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 sck  input  1  I2S bit clock, asynchronous to clk.
REQ-006 lrclk  input  1  I2S word select; 0 = left, 1 = right.
REQ-007 dat  input  1  I2S serial data, MSB first.
REQ-008 frame_ready  input  1  consumer accepts the frame when high with frame_valid.
REQ-009 err_clr  input  1  one-cycle pulse that clears overrun and sync_err.
REQ-010 left_data  output  SAMPLE_WIDTH  left sample of the presented frame.
REQ-011 right_data  output  SAMPLE_WIDTH  right sample of the presented frame.
REQ-012 frame_valid  output  1  a stereo frame is presented.
REQ-013 overrun  output  1  sticky: a completed frame was dropped.
REQ-014 sync_err  output  1  sticky: a word had the wrong bit count.

Function
REQ-015 sck, lrclk and dat SHALL each pass through a 2-flop synchronizer, followed by one further delay stage for edge detection.
REQ-016 An SCK rising edge SHALL be detected as synchronized sck high with the delayed copy low, giving one single-cycle strobe per SCK period.
REQ-017 On each strobe, synchronized dat and lrclk SHALL be sampled; lrclk_prev SHALL hold the lrclk value sampled on the previous strobe.
REQ-018 Framing SHALL follow standard I2S: a strobe with lrclk != lrclk_prev carries the LSB of the word for channel lrclk_prev, and the next strobe carries the MSB of the new channel.
REQ-019 A bit counter SHALL count bits per word, saturating at BITS_PER_CHANNEL+1, and reset to 0 after each word end.
REQ-020 Bits with index < SAMPLE_WIDTH SHALL shift into a SAMPLE_WIDTH shift register; later bits SHALL be ignored.
REQ-021 The FSM SHALL have states ACQUIRE, LEFT and RIGHT; the reset state is ACQUIRE.
REQ-022 ACQUIRE SHALL go to LEFT on the first strobe with lrclk_prev=1 and lrclk=0; bits received before this SHALL be discarded.
REQ-023 At a LEFT word end the shift register SHALL latch into a pending-left register and the FSM SHALL go to RIGHT.
REQ-024 At a RIGHT word end the frame (pending left, shift register) SHALL complete and the FSM SHALL go to LEFT.
REQ-025 A word whose count at word end is not BITS_PER_CHANNEL SHALL set sync_err, discard the current frame, and take the FSM to ACQUIRE.
REQ-026 A completed frame SHALL load left_data/right_data and set frame_valid in the cycle after the word-end strobe; latency is 1 clk.
REQ-027 Outputs SHALL hold stable while frame_valid=1; frame_valid SHALL clear on the cycle after frame_valid & frame_ready unless a new frame loads in that same cycle.
REQ-028 If a frame completes while frame_valid=1 and frame_ready=0, the new frame SHALL be dropped and overrun set; the held frame SHALL be unchanged.
REQ-029 If a frame completes in the same cycle as a handshake, the new frame SHALL load, frame_valid SHALL stay 1, and overrun SHALL not be set.
REQ-030 err_clr SHALL clear both sticky flags; an error event in the same cycle as err_clr SHALL win, leaving the flag set.

Reset
REQ-031 With rst_n low, all outputs SHALL be 0, the FSM SHALL be in ACQUIRE, and counters, shift, pending and synchronizer registers SHALL be 0.
REQ-032 Reset asserted mid-word SHALL abandon the partial word; after release the block SHALL re-acquire per REQ-022.

Structure
REQ-033 No shared package is needed; the FSM state encoding SHALL be local constants.
REQ-034 One sub-module, i2s_sync, SHALL implement the synchronizer and edge detector, one instance per input.

Verification
REQ-035 Drive i2s_tx-style stream, SCK = clk/16, L=0xA5A5A5, R=0x5A5A5A, 32-bit slots, frame_ready=1 -> one frame_valid pulse per frame with those values; flags stay 0.
REQ-036 Start the stream mid-right-word -> no frame is output until the first full L/R pair; no sync_err.
REQ-037 frame_ready=0 across two frames -> first frame is held, second is dropped, overrun=1; err_clr pulse -> overrun=0.
REQ-038 Shorten one left word to 31 bits -> sync_err=1, that frame is not output, and the next correct frame after re-acquire is output.
REQ-039 Assert frame_ready in the exact cycle a new frame completes -> the new frame loads, overrun stays 0.
REQ-040 Pulse rst_n low mid-word -> all outputs are 0 immediately; re-acquisition follows per REQ-036.
